// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Used by dmem_responder and its RAM; LED MMIO is gated by DMEM_MMIO_LED_EN.
package dmem_responder_pkg;
   localparam int XLEN = 32;
   localparam int ALEN = 32;
   localparam int LED_WIDTH = 4;
   localparam int RAM_MEMORY_SIZE = 1024;
   localparam logic [ALEN-1:0] MMIO_LED_ADDR = 32'hFFFF_FFF0;
   localparam int DMEM_MAX_READ_LATENCY = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   function automatic logic [ALEN-3:0] word_index(input logic [ALEN-1:0] addr);
      return addr[ALEN-1:2];
   endfunction
endpackage

// File: rtl/dmem_bram.sv
// Single-port RAM with per-byte write enables and registered read.
// Kept free of reset so FPGA tools infer block RAM.
module dmem_bram
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH = RAM_MEMORY_SIZE,
   parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk,
   input  logic            en,
   input  logic            we,
   input  logic [AW-1:0]   addr,
   input  logic [3:0]      be,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata
);
   logic [XLEN-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end
endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core load/store port: one request, one response.
// Define DMEM_MMIO_LED_EN to map LED_ADDR onto an LED register.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = RAM_MEMORY_SIZE,
   parameter int READ_LATENCY = 1,
   parameter logic [ALEN-1:0] LED_ADDR = MMIO_LED_ADDR
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ALEN-1:0]      req_addr,
   input  logic [XLEN-1:0]      req_wdata,
   input  logic [3:0]           req_be,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [XLEN-1:0]      rsp_rdata,
   output logic                 rsp_err
`ifdef DMEM_MMIO_LED_EN
   ,
   output logic [LED_WIDTH-1:0] led_out
`endif
);
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = $clog2(DMEM_MAX_READ_LATENCY + 1);
   localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);

   if (READ_LATENCY < 1 || READ_LATENCY > DMEM_MAX_READ_LATENCY) begin : g_bad_lat
      $error("dmem_responder: READ_LATENCY out of range");
   end
   if (LED_ADDR[1:0] != 2'b00) begin : g_bad_led
      $error("dmem_responder: LED_ADDR must be word aligned");
   end

   dmem_state_t     state;
   dmem_state_t     state_nx;
   logic [CW-1:0]   cnt;
   logic [ALEN-3:0] idx;
   logic            accept;
   logic            in_range;
   logic            is_led;
   logic            ram_en;
   logic [XLEN-1:0] ram_rdata;
   logic            unused_bits;

   assign idx = word_index(req_addr);
   assign in_range = idx < (ALEN-2)'(DEPTH_WORDS);
   assign unused_bits = ^req_addr[1:0];

`ifdef DMEM_MMIO_LED_EN
   assign is_led = (idx == word_index(LED_ADDR));
`else
   assign is_led = 1'b0;
`endif

   assign req_ready = rst_n && (state == IDLE);
   assign accept = req_valid && req_ready;
   assign ram_en = accept && in_range && !is_led;
   assign rsp_valid = (state == RESP);

   dmem_bram #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_bram (
      .clk   (clk),
      .en    (ram_en),
      .we    (req_we),
      .addr  (idx[AW-1:0]),
      .be    (req_be),
      .wdata (req_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (!req_we && in_range && !is_led) state_nx = WAIT;
               else                                state_nx = RESP;
            end
         end
         WAIT: if (cnt == LAT) state_nx = RESP;
         RESP: if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Response payload is latched once and held for the whole RESP state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  cnt       <= (state_nx == WAIT) ? CW'(1) : '0;
                  rsp_err   <= !in_range && !is_led;
                  rsp_rdata <= '0;
`ifdef DMEM_MMIO_LED_EN
                  if (is_led && !req_we)
                     rsp_rdata <= {{(XLEN-LED_WIDTH){1'b0}}, led_out};
`endif
               end
            end
            WAIT: begin
               if (cnt == LAT) begin
                  rsp_rdata <= ram_rdata;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DMEM_MMIO_LED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         led_out <= '0;
      else if (accept && is_led && req_we && req_be[0])
         led_out <= req_wdata[LED_WIDTH-1:0];
   end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus random traffic
// compared every cycle against a transaction-level memory model.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int DEPTH = 256;
   localparam int RL = 2;
   localparam logic [31:0] LEDA = 32'hFFFF_FFF0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_MMIO_LED_EN
   logic [LED_WIDTH-1:0] led_out;
`endif

   dmem_responder #(
      .DEPTH_WORDS  (DEPTH),
      .READ_LATENCY (RL),
      .LED_ADDR     (LEDA)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
`ifdef DMEM_MMIO_LED_EN
      ,
      .led_out   (led_out)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic chk1(string name, logic act, logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic timeout(string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Transaction-level model: memory image, LED value, one pending response.
   logic [31:0] mem_m [DEPTH];
   logic [3:0]  led_m = '0;
   bit          busy = 0;
   bit          pend_acc = 0;
   bit          pend_done = 0;
   int          age = 0;
   int          lat = 1;
   logic [31:0] exp_rd = '0;
   logic        exp_err = 1'b0;

   always @(negedge clk) begin : mon
      logic [29:0] widx;
      bit          ev;
      if (!rst_n) begin
         busy = 0;
         pend_acc = 0;
         pend_done = 0;
         led_m = '0;
         chk1("rst_rsp_valid", rsp_valid, 1'b0);
         chk1("rst_req_ready", req_ready, 1'b0);
      end else begin
         if (pend_acc) begin
            busy = 1;
            age = 1;
         end else if (busy) begin
            age++;
         end
         if (pend_done) busy = 0;
         pend_acc = 0;
         pend_done = 0;
         ev = busy && (age >= lat);
         chk1("req_ready", req_ready, !busy);
         chk1("rsp_valid", rsp_valid, ev);
         if (ev) begin
            chk32("rsp_rdata", rsp_rdata, exp_rd);
            chk1("rsp_err", rsp_err, exp_err);
         end
`ifdef DMEM_MMIO_LED_EN
         chk32("led_out", {28'b0, led_out}, {28'b0, led_m});
`endif
         if (ev && rsp_ready) begin
            pend_done = 1;
         end else if (!busy && req_valid) begin
            pend_acc = 1;
            widx = req_addr[31:2];
            exp_rd = '0;
            exp_err = 1'b0;
            lat = 1;
`ifdef DMEM_MMIO_LED_EN
            if (widx == LEDA[31:2]) begin
               if (!req_we) exp_rd = {28'b0, led_m};
               else if (req_be[0]) led_m = req_wdata[3:0];
            end else
`endif
            if (widx >= 30'(DEPTH)) begin
               exp_err = 1'b1;
            end else if (req_we) begin
               for (int i = 0; i < 4; i++)
                  if (req_be[i]) mem_m[widx][8*i +: 8] = req_wdata[8*i +: 8];
            end else begin
               exp_rd = mem_m[widx];
               lat = RL + 1;
            end
         end
      end
   end

   task automatic xfer(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int hold, output logic [31:0] rd,
                       output logic e, output int lat_o);
      int n;
      logic [31:0] r;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_we = we;
      req_addr = addr;
      req_wdata = wd;
      req_be = be;
      rsp_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) timeout("accept");
      @(posedge clk); #1;
      r = $urandom;
      req_valid = r[0];
      req_we = r[1];
      req_be = r[7:4];
      req_addr = $urandom;
      req_wdata = $urandom;
      lat_o = 1;
      @(negedge clk);
      while (!rsp_valid && lat_o < 20) begin
         @(negedge clk);
         lat_o++;
      end
      if (lat_o >= 20) timeout("response");
      rd = rsp_rdata;
      e = rsp_err;
      repeat (hold) begin
         @(negedge clk);
         chk1("bp_valid", rsp_valid, 1'b1);
         chk32("bp_rdata", rsp_rdata, rd);
         chk1("bp_req_ready", req_ready, 1'b0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        e;
      int          l;
      logic [31:0] r;
      logic [31:0] a;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("reset_req_ready", req_ready, 1'b0);
      chk1("reset_rsp_valid", rsp_valid, 1'b0);
      chk32("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk1("reset_rsp_err", rsp_err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("release_req_ready", req_ready, 1'b1);

      for (int i = 0; i < DEPTH; i++)
         xfer(1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, e, l);

      xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 0, rd, e, l);
      chk1("st_err", e, 1'b0);
      chk32("st_latency", 32'(l), 32'd1);
      xfer(1'b0, 32'h100, 32'h0, 4'b0000, 0, rd, e, l);
      chk32("ld_full", rd, 32'hDEADBEEF);
      chk1("ld_err", e, 1'b0);
      chk32("ld_latency", 32'(l), 32'(RL + 1));

      xfer(1'b1, 32'h100, 32'h0000AA00, 4'b0010, 0, rd, e, l);
      xfer(1'b0, 32'h100, 32'h0, 4'b0000, 0, rd, e, l);
      chk32("ld_lane1", rd, 32'hDEADAAEF);
      xfer(1'b1, 32'h100, 32'h12340000, 4'b1100, 0, rd, e, l);
      xfer(1'b0, 32'h102, 32'h0, 4'b0101, 0, rd, e, l);
      chk32("ld_upper", rd, 32'h1234AAEF);

      xfer(1'b0, 32'h100, 32'h0, 4'b0000, 5, rd, e, l);
      chk32("bp_ld", rd, 32'h1234AAEF);

      xfer(1'b1, 32'h0, 32'h11223344, 4'hF, 0, rd, e, l);
      xfer(1'b0, 32'(DEPTH * 4), 32'h0, 4'hF, 0, rd, e, l);
      chk1("oor_ld_err", e, 1'b1);
      chk32("oor_ld_rdata", rd, 32'h0);
      chk32("oor_ld_latency", 32'(l), 32'd1);
      xfer(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 0, rd, e, l);
      chk1("oor_st_err", e, 1'b1);
      xfer(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, e, l);
      chk32("no_wrap", rd, 32'h11223344);

      xfer(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 0, rd, e, l);
      chk1("be0_err", e, 1'b0);
      xfer(1'b0, 32'h100, 32'h0, 4'hF, 0, rd, e, l);
      chk32("be0_noop", rd, 32'h1234AAEF);

      xfer(1'b1, LEDA, 32'h5, 4'b0001, 0, rd, e, l);
`ifdef DMEM_MMIO_LED_EN
      chk1("led_st_err", e, 1'b0);
      chk32("led_value", {28'b0, led_out}, 32'h5);
      xfer(1'b0, LEDA, 32'h0, 4'b0000, 0, rd, e, l);
      chk32("led_ld", rd, 32'h5);
      chk32("led_ld_latency", 32'(l), 32'd1);
`else
      chk1("led_absent_err", e, 1'b1);
`endif

      @(posedge clk); #1;
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 32'h100;
      req_be = 4'h0;
      @(negedge clk);
      chk1("wait_rst_pre_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk1("wait_rst_valid", rsp_valid, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk1("wait_rst_release_ready", req_ready, 1'b1);
      xfer(1'b0, 32'h100, 32'h0, 4'hF, 0, rd, e, l);
      chk32("post_rst_ld", rd, 32'h1234AAEF);

      @(posedge clk); #1;
      req_valid = 1'b1;
      req_we = 1'b1;
      req_addr = 32'h200;
      req_wdata = 32'hCAFEF00D;
      req_be = 4'hF;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk1("resp_rst_pre_valid", rsp_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("resp_rst_valid", rsp_valid, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      xfer(1'b0, 32'h200, 32'h0, 4'hF, 0, rd, e, l);
      chk32("store_survives_rst", rd, 32'hCAFEF00D);

      for (int i = 0; i < 250; i++) begin
         r = $urandom;
         if (r[3:0] < 4'd11)
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
         else if (r[3:0] < 4'd14)
            a = 32'($urandom_range(DEPTH, DEPTH + 8) * 4);
         else if (r[3:0] == 4'd14)
            a = $urandom | 32'h8000_0000;
         else
            a = LEDA;
         a[1:0] = r[5:4];
         xfer(r[8], a, $urandom, r[15:12], int'(r[17:16]), rd, e, l);
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
